// File: rtl/pc_sequencer_if.sv
// Fetch-stage PC sequencer bus: hazard/branch controls in, NPC + strobes out.
// master = control side driving requests, slave = the pc_sequencer itself.
interface pc_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              stall;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_target;
  logic              br_taken;
  logic [ADDR_W-1:0] br_target;
  logic              halt_req;
  logic [ADDR_W-1:0] NPC;
  logic              fetch_valid;
  logic              flush;
  logic [2:0]        state;
`ifdef PC_BOUNDS_CHECK_EN
  logic              pc_err;
`endif

  modport master (
`ifdef PC_BOUNDS_CHECK_EN
    input  pc_err,
`endif
    output stall,
    output jmp,
    output jmp_target,
    output br_taken,
    output br_target,
    output halt_req,
    input  NPC,
    input  fetch_valid,
    input  flush,
    input  state
  );

  modport slave (
`ifdef PC_BOUNDS_CHECK_EN
    output pc_err,
`endif
    input  stall,
    input  jmp,
    input  jmp_target,
    input  br_taken,
    input  br_target,
    input  halt_req,
    output NPC,
    output fetch_valid,
    output flush,
    output state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: increment/stall/jump/branch/halt arbitration for IF.
// Ports: clk, rst (sync, high), bus (pc_sequencer_if.slave). Opt: PC_BOUNDS_CHECK_EN.
module pc_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int RESET_PC     = 0,
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_LIMIT     = 255
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    A_IDLE,
    A_START,
    A_REDIR,
    A_INC,
    A_ERR
  } act_e;

  localparam logic [ADDR_W-1:0] RST_PC =
    ADDR_W'(RESET_PC);
  localparam logic [2:0] CNT_LD =
    3'(FLUSH_CYCLES - 1);
  localparam state_e REDIR_ST =
    (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;

  state_e            state_q, state_d;
  act_e              act;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [ADDR_W-1:0] tgt, nxt;
  logic              fv_q, fv_d;
  logic              flush_q, flush_d;
  logic [2:0]        cnt_q, cnt_d;

`ifdef PC_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(PC_LIMIT);
  logic [ADDR_W:0]   wide;
  logic              err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RESET;
    else     state_q <= state_d;
  end

  // Picks the action for this edge; the older EX branch beats the ID jump.
  always_comb begin
    act     = A_IDLE;
    state_d = state_q;
    tgt     = bus.br_taken ? bus.br_target
                           : bus.jmp_target;
    unique case (state_q)
      S_RESET: begin
        act     = A_START;
        state_d = S_RUN;
      end
      S_RUN, S_STALL: begin
        priority case (1'b1)
          bus.br_taken, bus.jmp: begin
            act     = A_REDIR;
            state_d = REDIR_ST;
          end
          bus.halt_req: state_d = S_HALT;
          bus.stall:    state_d = S_STALL;
          default: begin
            act     = A_INC;
            state_d = S_RUN;
          end
        endcase
      end
      // The jumping instruction is being squashed, so only branches count.
      S_FLUSH: begin
        if (bus.br_taken) begin
          act     = A_REDIR;
          state_d = REDIR_ST;
        end else begin
          act     = A_INC;
          state_d = (cnt_q == 3'd0) ? S_RUN
                                    : S_FLUSH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    nxt = (act == A_REDIR) ? tgt
                           : npc_q + 1'b1;
`ifdef PC_BOUNDS_CHECK_EN
    // One extra bit so the all-ones wrap also counts as out of range.
    wide = (act == A_REDIR) ? {1'b0, tgt}
                            : {1'b0, npc_q} + 1'b1;
    if ((act == A_REDIR || act == A_INC)
        && wide > LIMIT) begin
      act     = A_ERR;
      state_d = S_HALT;
    end
`endif
  end

  always_comb begin
    npc_d   = npc_q;
    fv_d    = 1'b0;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (act)
      A_START: fv_d = 1'b1;
      A_REDIR: begin
        npc_d   = nxt;
        fv_d    = 1'b1;
        flush_d = 1'b1;
        cnt_d   = CNT_LD;
      end
      A_INC: begin
        npc_d = nxt;
        fv_d  = 1'b1;
        if (state_q == S_FLUSH
            && cnt_q != 3'd0) begin
          flush_d = 1'b1;
          cnt_d   = cnt_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

`ifdef PC_BOUNDS_CHECK_EN
  always_comb begin
    err_d = err_q | (act == A_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.pc_err = err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      npc_q   <= RST_PC;
      fv_q    <= 1'b0;
      flush_q <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      npc_q   <= npc_d;
      fv_q    <= fv_d;
      flush_q <= flush_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.NPC         = npc_q;
  assign bus.fetch_valid = fv_q;
  assign bus.flush       = flush_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed cases then random traffic
// compared against a behavioural model of the sequencing rules.
module tb_pc_sequencer;

  localparam int AW  = 8;
  localparam int RPC = 0;
  localparam int FC  = 2;
  localparam int LIM = 254;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(AW)) bus ();

  pc_sequencer #(
    .ADDR_W      (AW),
    .RESET_PC    (RPC),
    .FLUSH_CYCLES(FC),
    .PC_LIMIT    (LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // model: state number, PC, strobes, flush cycles already shown
  int m_npc, m_fv, m_fl, m_st, m_seen, m_err;

  task automatic chk(input string tag,
                     input int obs,
                     input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic bit legal(input int v);
`ifdef PC_BOUNDS_CHECK_EN
    return v <= LIM;
`else
    return v >= 0;
`endif
  endfunction

  function automatic void trap();
    m_err = 1;
    m_fv  = 0;
    m_fl  = 0;
    m_st  = 4;
  endfunction

  function automatic void redirect(input int t);
    if (!legal(t)) trap();
    else begin
      m_npc  = t;
      m_fv   = 1;
      m_fl   = 1;
      m_seen = 1;
      m_st   = (FC > 1) ? 3 : 1;
    end
  endfunction

  function automatic void advance(input bit in_fl);
    int nv;
    nv = m_npc + 1;
    if (!legal(nv)) trap();
    else begin
      m_npc = nv % (1 << AW);
      m_fv  = 1;
      if (in_fl && m_seen < FC) begin
        m_seen++;
        m_fl = 1;
      end else begin
        m_fl = 0;
        m_st = 1;
      end
    end
  endfunction

  function automatic void model();
    if (rst) begin
      m_npc  = RPC;
      m_fv   = 0;
      m_fl   = 0;
      m_st   = 0;
      m_seen = 0;
      m_err  = 0;
      return;
    end
    case (m_st)
      0: begin
        m_st = 1;
        m_fv = 1;
        m_fl = 0;
      end
      1, 2: begin
        if (bus.br_taken)
          redirect(int'(bus.br_target));
        else if (bus.jmp)
          redirect(int'(bus.jmp_target));
        else if (bus.halt_req) begin
          m_fv = 0; m_fl = 0; m_st = 4;
        end else if (bus.stall) begin
          m_fv = 0; m_fl = 0; m_st = 2;
        end else advance(1'b0);
      end
      3: begin
        if (bus.br_taken)
          redirect(int'(bus.br_target));
        else advance(1'b1);
      end
      default: begin
        m_fv = 0;
        m_fl = 0;
      end
    endcase
  endfunction

  task automatic check_all();
    chk("npc",   int'(bus.NPC),         m_npc);
    chk("fv",    int'(bus.fetch_valid), m_fv);
    chk("flush", int'(bus.flush),       m_fl);
    chk("state", int'(bus.state),       m_st);
`ifdef PC_BOUNDS_CHECK_EN
    chk("err",   int'(bus.pc_err),      m_err);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    check_all();
  endtask

  task automatic drive(input bit s,
                       input bit j,
                       input int jt,
                       input bit b,
                       input int bt,
                       input bit h);
    bus.stall      = s;
    bus.jmp        = j;
    bus.jmp_target = AW'(jt);
    bus.br_taken   = b;
    bus.br_target  = AW'(bt);
    bus.halt_req   = h;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    // 1: reset then sequential fetch
    step(); step(); step();
    chk("rst_npc",   int'(bus.NPC), 0);
    chk("rst_fv",    int'(bus.fetch_valid), 0);
    chk("rst_state", int'(bus.state), 0);
    rst = 1'b0;
    step();
    chk("rel_npc", int'(bus.NPC), 0);
    chk("rel_fv",  int'(bus.fetch_valid), 1);
    step(); step(); step();
    chk("seq3",    int'(bus.NPC), 3);
    chk("seq_run", int'(bus.state), 1);
    // 2: stall at 5
    step(); step();
    drive(1, 0, 0, 0, 0, 0);
    step(); step();
    chk("stall_npc", int'(bus.NPC), 5);
    chk("stall_st",  int'(bus.state), 2);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("unstall", int'(bus.NPC), 6);
    // 3: jump at 9
    step(); step(); step();
    drive(0, 1, 'h40, 0, 0, 0);
    step();
    chk("jmp_npc", int'(bus.NPC), 'h40);
    chk("jmp_fl",  int'(bus.flush), 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("jmp_41", int'(bus.NPC), 'h41);
    step();
    chk("jmp_42", int'(bus.NPC), 'h42);
    chk("jmp_fl0", int'(bus.flush), 0);
    // 4: branch beats jump
    drive(0, 1, 'h80, 1, 'h10, 0);
    step();
    chk("br_win", int'(bus.NPC), 'h10);
    chk("br_fl",  int'(bus.flush), 1);
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    // branch reload in FLUSH, jmp ignored there
    drive(0, 0, 0, 1, 'h50, 0);
    step();
    drive(0, 1, 'h70, 0, 0, 0);
    step();
    chk("fl_nojmp", int'(bus.NPC), 'h51);
    drive(0, 0, 0, 1, 'h58, 0);
    step();
    chk("fl_rebr", int'(bus.NPC), 'h58);
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    // branch overrides a stall
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(1, 0, 0, 1, 'h60, 0);
    step();
    chk("stall_br", int'(bus.NPC), 'h60);
    chk("stall_br_st", int'(bus.state), 3);
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    // 5: wrap / bounds
    drive(0, 1, 'hFD, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step(); step();
`ifdef PC_BOUNDS_CHECK_EN
    chk("bnd_err", int'(bus.pc_err), 1);
    chk("bnd_st",  int'(bus.state), 4);
    chk("bnd_npc", int'(bus.NPC), 'hFE);
`else
    chk("at_ff", int'(bus.NPC), 'hFF);
    step();
    chk("wrap", int'(bus.NPC), 0);
`endif
    // 6: halt, then reset mid-flush
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    drive(0, 0, 0, 0, 0, 1);
    step();
    chk("halt_st", int'(bus.state), 4);
    chk("halt_fv", int'(bus.fetch_valid), 0);
    drive(1, 1, 'h33, 0, 0, 0);
    step();
    chk("halt_hold", int'(bus.state), 4);
    chk("halt_npc",  int'(bus.NPC), 0);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    drive(0, 1, 'h20, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    chk("rf_npc", int'(bus.NPC), 0);
    chk("rf_fl",  int'(bus.flush), 0);
    rst = 1'b0;
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom % 30) == 0;
      drive(($urandom % 4) == 0,
            ($urandom % 8) == 0,
            int'($urandom % 256),
            ($urandom % 8) == 0,
            int'($urandom % 256),
            ($urandom % 40) == 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
